sdram_cache: RTL and testbench
==============================

Name:
sdram_cache

Overview:
- Unified direct-mapped, write-back, write-allocate data cache between two CPU-side Avalon-MM slave ports (s0, s1) and one SDRAM-side Avalon-MM master (m0).
- Both slave ports share one tag/data array, and only one port is served per cycle.
- Misses evict the dirty victim line to the SDRAM, then refill the line with single-word transfers on m0.

Parameters:
- SIZE, 8192, cache data capacity in bytes. Must be a power of two and at least 64.
- Line size is fixed at 32 bytes (8 words), so the design has SIZE/32 lines.

Ports:
- Clock and reset are `clk` and `rest`: one clock, and reset is synchronous and active-high.
- clk  in  1  clock.
- rest  in  1  reset.
- s0_address  in  32  byte address (word-aligned).
- s0_byteEnable  in  4  byte lanes.
- s0_read  in  1  read request.
- s0_readData  out  32  read data.
- s0_write  in  1  write request.
- s0_writeData  in  32  write data.
- s0_waitRequest  out  1  request not accepted this cycle.
- s0_readDataValid  out  1  s0_readData valid.
- s1_* (eight signals)  same directions, widths and meanings as s0_*.
- m0_address  out  32  SDRAM byte address.
- m0_byteEnable  out  4  byte lanes; always 4'hf.
- m0_read  out  1  read command.
- m0_readData  in  32  returned data.
- m0_write  out  1  write command.
- m0_writeData  out  32  write data.
- m0_waitRequest  in  1  SDRAM stall.
- m0_readDataValid  in  1  m0_readData valid.
- m0_beginBurstTransfer  out  1  pulses with every accepted-cycle command.
- m0_burstCount  out  8  constant 1.

Behaviour:
- Address split:
  - word offset = addr[4:2]
  - index = addr[log2(SIZE)-1:5]
  - tag = addr[31:log2(SIZE)]
- Per-line state: valid bit and dirty bit, held in flops.
- Reset (while rest=1, synchronous):
  - all valid and dirty bits clear.
  - FSM goes to IDLE.
  - s0/s1_readDataValid=0, s0/s1_readData=0.
  - m0_read=0, m0_write=0, m0_beginBurstTransfer=0, m0_address=0.
  - s0/s1_waitRequest=1.
- Reset mid-refill or mid-writeback: the operation is aborted immediately. Any m0_readDataValid arriving after reset is ignored.
- Arbitration: s0 has fixed priority over s1. s1 is serviced only in an IDLE cycle with no s0 request; otherwise s1_waitRequest=1.
- IDLE with a hit on the selected port:
  - waitRequest=0 combinationally in the same cycle, and the request is accepted at that clock edge.
  - Read hit: readData is registered and readDataValid=1 for exactly one cycle, starting the cycle after acceptance.
  - Write hit: merge the enabled bytes into the word and set dirty. No response beat.
- IDLE with a miss (invalid, or tag mismatch): waitRequest=1 and the FSM moves to WB if the victim is valid and dirty, otherwise to FILL.
- WB state:
  - Issue 8 single writes at {victimTag, index, word, 2'b00} for word=0..7.
  - Each command is held until m0_waitRequest=0.
  - Then go to FILL.
- FILL state:
  - Issue 8 reads at {reqTag, index, word, 2'b00}. Reads may be pipelined, advancing on m0_waitRequest=0.
  - Store the m0_readDataValid beats in order into words 0..7.
  - After the 8th beat: valid=1, dirty=0, tag updated, back to IDLE.
  - The pending request is still asserted and now hits (re-arbitrated, so s0 still wins).
- m0 commands are never asserted in IDLE. m0_read and m0_write are never simultaneous.
- A request with both read and write asserted is treated as a write.
- byteEnable=0 on a write hit leaves data unchanged but still sets dirty.

Test Plan:
1. Reset, then wait for s0_waitRequest=0. Write 0x12345678 (be=f) at 8.
   - Required: miss, 8 m0 reads at 0x0..0x1C, no m0 writes.
   - Then read 8 → readDataValid one cycle after accept, data 0x12345678.
2. Write 0x69325678 at 8+2048, 0x32695678 at 8+4096, 0x43215678 at 8+6144, 0x58585678 at 8+8192.
   - Required: the last write evicts the line at index 0. m0 shows 8 writes starting at address 0 with word 2 = 0x12345678, followed by refill reads at 0x2000.
3. Read 8 after scenario 2.
   - Required: writeback of 0x2000 line (word 2 = 0x58585678), refill from 0x0, returned data 0x12345678.
4. Write 0xAABBCCDD be=4'b0011 onto a word holding 0x12345678, then read it.
   - Required: read returns 0x1234CCDD.
5. s0 and s1 both request hits in the same cycle.
   - Required: s0 accepted first and s1_waitRequest=1 that cycle. s1 accepted the next cycle and returns its correct data.
6. Assert rest during FILL (after 3 m0 beats).
   - Required: m0_read drops the next cycle. After reset, a read of the same address misses again and refills fully from SDRAM.

Source files
------------

// File: rtl/sdram_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_cache                                                |
// | Description : Unified direct-mapped, write-back, write-allocate data     |
// |               cache. Two CPU-side Avalon-MM slave ports (s0, s1) share   |
// |               one tag/data array. s0 has fixed priority over s1. A miss  |
// |               writes back the dirty victim line and then refills the     |
// |               32-byte line with single-word transfers on one Avalon-MM   |
// |               master (m0) to the SDRAM.                                  |
// | Ports       : clk, rest           - clock, sync active-high reset        |
// |               s0_* / s1_*         - CPU slave ports (addr, be, rd, wr,   |
// |                                     wdata, rdata, waitreq, rdvalid)      |
// |               m0_*                - SDRAM master port (single-word       |
// |                                     commands, pipelined reads)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sdram_cache #(
  parameter int SIZE = 8192
) (
  input  logic        clk,
  input  logic        rest,

  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteEnable,
  input  logic        s0_read,
  output logic [31:0] s0_readData,
  input  logic        s0_write,
  input  logic [31:0] s0_writeData,
  output logic        s0_waitRequest,
  output logic        s0_readDataValid,

  input  logic [31:0] s1_address,
  input  logic [3:0]  s1_byteEnable,
  input  logic        s1_read,
  output logic [31:0] s1_readData,
  input  logic        s1_write,
  input  logic [31:0] s1_writeData,
  output logic        s1_waitRequest,
  output logic        s1_readDataValid,

  output logic [31:0] m0_address,
  output logic [3:0]  m0_byteEnable,
  output logic        m0_read,
  input  logic [31:0] m0_readData,
  output logic        m0_write,
  output logic [31:0] m0_writeData,
  input  logic        m0_waitRequest,
  input  logic        m0_readDataValid,
  output logic        m0_beginBurstTransfer,
  output logic [7:0]  m0_burstCount
);

  localparam int ADDR_W = $clog2(SIZE);   // byte-offset bits covered by the cache
  localparam int IDX_W  = ADDR_W - 5;     // line index width
  localparam int TAG_W  = 32 - ADDR_W;    // tag width
  localparam int LINES  = SIZE / 32;
  localparam int WORDS  = SIZE / 4;
  localparam int WIDX_W = IDX_W + 3;      // word index into the data array

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t state, state_next;

  // Storage: data and tags as plain arrays (RAM-friendly), valid/dirty in flops
  // so they can be cleared in one reset cycle.
  logic [31:0]      data_mem [WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_bits;
  logic [LINES-1:0] dirty_bits;

  // Miss bookkeeping, captured when a miss leaves IDLE.
  logic [TAG_W-1:0] miss_tag;
  logic [TAG_W-1:0] victim_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [2:0]       wb_cnt;     // next writeback word
  logic [3:0]       cmd_cnt;    // refill read commands issued (0..8)
  logic [2:0]       beat_cnt;   // refill beats received

  // Request arbitration (s0 wins whenever it asks).
  logic              req0, req1, req_any, sel1, req_wr;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_be;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [2:0]        req_word;
  logic [WIDX_W-1:0] req_widx;
  logic              hit;
  logic [31:0]       cur_word;
  logic [31:0]       merged;

  // FSM side outputs
  logic accept;
  logic miss_go;
  logic fill_beat;
  logic fill_last;

  // Byte-offset bits of the CPU addresses are ignored (word-aligned accesses).
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s0_address[1:0], s1_address[1:0]};

  assign req0    = s0_read | s0_write;
  assign req1    = s1_read | s1_write;
  assign req_any = req0 | req1;
  assign sel1    = ~req0 & req1;

  // A request with both read and write asserted is handled as a write.
  assign req_wr    = sel1 ? s1_write      : s0_write;
  assign req_addr  = sel1 ? s1_address    : s0_address;
  assign req_wdata = sel1 ? s1_writeData  : s0_writeData;
  assign req_be    = sel1 ? s1_byteEnable : s0_byteEnable;

  assign req_idx  = req_addr[ADDR_W-1:5];
  assign req_tag  = req_addr[31:ADDR_W];
  assign req_word = req_addr[4:2];
  assign req_widx = {req_idx, req_word};

  assign hit      = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
  assign cur_word = data_mem[req_widx];

  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (req_be[b]) begin
        merged[8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
  end

  // Refill beats only count while a refill is genuinely in flight; stray
  // beats arriving after a reset land in IDLE and are dropped.
  assign fill_beat = (state == FILL) && m0_readDataValid && !rest;
  assign fill_last = fill_beat && (beat_cnt == 3'd7);

  // Each single-word command is its own one-beat burst.
  assign m0_byteEnable         = 4'hf;
  assign m0_burstCount         = 8'd1;
  assign m0_beginBurstTransfer = m0_read | m0_write;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rest) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    s0_waitRequest = 1'b1;
    s1_waitRequest = 1'b1;
    accept         = 1'b0;
    miss_go        = 1'b0;
    m0_read        = 1'b0;
    m0_write       = 1'b0;
    m0_address     = 32'h0;
    m0_writeData   = 32'h0;

    if (!rest) begin
      case (state)
        IDLE: begin
          // Without a request the ports are ready; s1 must yield to any s0
          // request, and a miss holds the selected port off.
          s0_waitRequest = req0 & ~hit;
          s1_waitRequest = req0 | (req1 & ~hit);
          if (req_any) begin
            if (hit) begin
              accept = 1'b1;
            end else begin
              miss_go    = 1'b1;
              state_next = (valid_bits[req_idx] && dirty_bits[req_idx]) ? WB : FILL;
            end
          end
        end

        WB: begin
          m0_write     = 1'b1;
          m0_address   = {victim_tag, miss_idx, wb_cnt, 2'b00};
          m0_writeData = data_mem[{miss_idx, wb_cnt}];
          if (!m0_waitRequest && (wb_cnt == 3'd7)) begin
            state_next = FILL;
          end
        end

        FILL: begin
          // Reads are pipelined: commands keep issuing while beats return.
          if (!cmd_cnt[3]) begin
            m0_read    = 1'b1;
            m0_address = {miss_tag, miss_idx, cmd_cnt[2:0], 2'b00};
          end
          if (fill_last) begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control registers: valid/dirty, counters, CPU read responses
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rest) begin
      valid_bits       <= '0;
      dirty_bits       <= '0;
      miss_tag         <= '0;
      victim_tag       <= '0;
      miss_idx         <= '0;
      wb_cnt           <= 3'd0;
      cmd_cnt          <= 4'd0;
      beat_cnt         <= 3'd0;
      s0_readData      <= 32'h0;
      s1_readData      <= 32'h0;
      s0_readDataValid <= 1'b0;
      s1_readDataValid <= 1'b0;
    end else begin
      s0_readDataValid <= 1'b0;
      s1_readDataValid <= 1'b0;

      if (miss_go) begin
        miss_tag   <= req_tag;
        miss_idx   <= req_idx;
        victim_tag <= tag_mem[req_idx];
        wb_cnt     <= 3'd0;
        cmd_cnt    <= 4'd0;
        beat_cnt   <= 3'd0;
      end

      if (accept) begin
        if (req_wr) begin
          // Dirty is set even when no byte lane is enabled.
          dirty_bits[req_idx] <= 1'b1;
        end else if (sel1) begin
          s1_readData      <= cur_word;
          s1_readDataValid <= 1'b1;
        end else begin
          s0_readData      <= cur_word;
          s0_readDataValid <= 1'b1;
        end
      end

      if (m0_write && !m0_waitRequest) begin
        wb_cnt <= wb_cnt + 3'd1;
      end

      if (m0_read && !m0_waitRequest) begin
        cmd_cnt <= cmd_cnt + 4'd1;
      end

      if (fill_beat) begin
        beat_cnt <= beat_cnt + 3'd1;
        if (beat_cnt == 3'd7) begin
          valid_bits[miss_idx] <= 1'b1;
          dirty_bits[miss_idx] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Data and tag arrays (no reset; validity is tracked by valid_bits)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && req_wr) begin
      data_mem[req_widx] <= merged;
    end
    if (fill_beat) begin
      data_mem[{miss_idx, beat_cnt}] <= m0_readData;
    end
    if (fill_last) begin
      tag_mem[miss_idx] <= miss_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sdram_cache                                             |
// | Description : Directed self-checking bench for sdram_cache with a small  |
// |               SDRAM responder (periodic stalls, 3-cycle read latency).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sdram_cache;

  logic        clk = 1'b0;
  logic        rest;

  logic [31:0] s0_address, s0_writeData, s0_readData;
  logic [3:0]  s0_byteEnable;
  logic        s0_read, s0_write, s0_waitRequest, s0_readDataValid;
  logic [31:0] s1_address, s1_writeData, s1_readData;
  logic [3:0]  s1_byteEnable;
  logic        s1_read, s1_write, s1_waitRequest, s1_readDataValid;

  logic [31:0] m0_address, m0_writeData;
  logic [3:0]  m0_byteEnable;
  logic        m0_read, m0_write, m0_beginBurstTransfer;
  logic [7:0]  m0_burstCount;
  bit   [31:0] m0_readData;
  bit          m0_waitRequest;
  bit          m0_readDataValid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_cache #(.SIZE(8192)) dut (
    .clk                  (clk),
    .rest                 (rest),
    .s0_address           (s0_address),
    .s0_byteEnable        (s0_byteEnable),
    .s0_read              (s0_read),
    .s0_readData          (s0_readData),
    .s0_write             (s0_write),
    .s0_writeData         (s0_writeData),
    .s0_waitRequest       (s0_waitRequest),
    .s0_readDataValid     (s0_readDataValid),
    .s1_address           (s1_address),
    .s1_byteEnable        (s1_byteEnable),
    .s1_read              (s1_read),
    .s1_readData          (s1_readData),
    .s1_write             (s1_write),
    .s1_writeData         (s1_writeData),
    .s1_waitRequest       (s1_waitRequest),
    .s1_readDataValid     (s1_readDataValid),
    .m0_address           (m0_address),
    .m0_byteEnable        (m0_byteEnable),
    .m0_read              (m0_read),
    .m0_readData          (m0_readData),
    .m0_write             (m0_write),
    .m0_writeData         (m0_writeData),
    .m0_waitRequest       (m0_waitRequest),
    .m0_readDataValid     (m0_readDataValid),
    .m0_beginBurstTransfer(m0_beginBurstTransfer),
    .m0_burstCount        (m0_burstCount)
  );

  // ---------------------------------------------------------------------
  // SDRAM model: unwritten words read back as (address ^ 0xC0DE0000)
  // ---------------------------------------------------------------------
  bit [31:0]   sdram_mem [16384];
  bit          sdram_wr  [16384];
  bit [7:0]    stall_ctr;
  bit          p1_v, p2_v;
  bit [31:0]   p1_a, p2_a;
  int          beats_seen = 0;
  int          both_cnt   = 0;
  int          proto_err  = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];

  function automatic logic [31:0] sdram_rd(input logic [31:0] a);
    if (sdram_wr[a[15:2]]) return sdram_mem[a[15:2]];
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    stall_ctr      <= stall_ctr + 8'd1;
    m0_waitRequest <= (stall_ctr[1:0] == 2'd2);
    if (m0_read && m0_write) both_cnt <= both_cnt + 1;
    if ((m0_read || m0_write) &&
        (!m0_beginBurstTransfer || m0_burstCount != 8'd1 || m0_byteEnable != 4'hf))
      proto_err <= proto_err + 1;
    if (m0_write && !m0_waitRequest) begin
      sdram_mem[m0_address[15:2]] <= m0_writeData;
      sdram_wr[m0_address[15:2]]  <= 1'b1;
      wr_addr_q.push_back(m0_address);
      wr_data_q.push_back(m0_writeData);
    end
    if (m0_read && !m0_waitRequest) rd_addr_q.push_back(m0_address);
    p1_v             <= m0_read && !m0_waitRequest;
    p1_a             <= m0_address;
    p2_v             <= p1_v;
    p2_a             <= p1_a;
    m0_readDataValid <= p2_v;
    m0_readData      <= p2_v ? sdram_rd(p2_a) : 32'h0;
    if (p2_v) beats_seen <= beats_seen + 1;
  end

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic drive(input int port, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (port == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_writeData = d; s0_byteEnable = be;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_writeData = d; s1_byteEnable = be;
    end
  endtask

  // One CPU access; returns read data and the number of stalled cycles.
  task automatic access(input int port, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata, output int stalls);
    logic w;
    stalls = 0;
    @(negedge clk);
    drive(port, !wr, wr, a, d, be);
    #1;
    w = (port == 0) ? s0_waitRequest : s1_waitRequest;
    while (w && stalls < 3000) begin
      @(negedge clk);
      #1;
      stalls++;
      w = (port == 0) ? s0_waitRequest : s1_waitRequest;
    end
    check_eq("accept", {31'b0, w}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rdata = (port == 0) ? s0_readData : s1_readData;
    if (!wr) begin
      check_eq("rdv_beat", (port == 0) ? s0_readDataValid : s1_readDataValid, 32'd1);
      @(negedge clk);
      check_eq("rdv_single", (port == 0) ? s0_readDataValid : s1_readDataValid, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    int          st;
    int          b0;
    int          n;

    rest = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_s0_wait", s0_waitRequest, 32'd1);
    check_eq("rst_s1_wait", s1_waitRequest, 32'd1);
    check_eq("rst_s0_rdv", s0_readDataValid, 32'd0);
    check_eq("rst_s0_rdata", s0_readData, 32'd0);
    check_eq("rst_m0_read", m0_read, 32'd0);
    check_eq("rst_m0_write", m0_write, 32'd0);
    check_eq("rst_m0_addr", m0_address, 32'd0);
    check_eq("rst_m0_bbt", m0_beginBurstTransfer, 32'd0);
    rest = 1'b0;
    @(negedge clk);
    #1;
    check_eq("post_rst_wait", s0_waitRequest, 32'd0);

    // 1: write miss on an empty cache -> refill only, then read hit
    clear_logs();
    access(0, 1'b1, 32'h8, 32'h1234_5678, 4'hf, rd, st);
    check_eq("t1_miss_stalls", {31'b0, st > 0}, 32'd1);
    check_eq("t1_rd_cnt", rd_addr_q.size(), 32'd8);
    check_eq("t1_rd_first", qget(rd_addr_q, 0), 32'h0);
    check_eq("t1_rd_last", qget(rd_addr_q, 7), 32'h1C);
    check_eq("t1_wr_cnt", wr_addr_q.size(), 32'd0);
    access(0, 1'b0, 32'h8, 32'h0, 4'hf, rd, st);
    check_eq("t1_hit_nowait", st, 32'd0);
    check_eq("t1_rdata", rd, 32'h1234_5678);
    access(0, 1'b0, 32'hC, 32'h0, 4'hf, rd, st);
    check_eq("t1_fill_word3", rd, 32'hC0DE_000C);

    // 2: fill three more lines, then evict dirty line 0 with 0x2008
    access(0, 1'b1, 32'h0808, 32'h6932_5678, 4'hf, rd, st);
    access(0, 1'b1, 32'h1008, 32'h3269_5678, 4'hf, rd, st);
    access(0, 1'b1, 32'h1808, 32'h4321_5678, 4'hf, rd, st);
    clear_logs();
    access(0, 1'b1, 32'h2008, 32'h5858_5678, 4'hf, rd, st);
    check_eq("t2_wr_cnt", wr_addr_q.size(), 32'd8);
    check_eq("t2_wr_first", qget(wr_addr_q, 0), 32'h0);
    check_eq("t2_wr_last", qget(wr_addr_q, 7), 32'h1C);
    check_eq("t2_wr_word2", qget(wr_data_q, 2), 32'h1234_5678);
    check_eq("t2_wr_word0", qget(wr_data_q, 0), 32'hC0DE_0000);
    check_eq("t2_rd_cnt", rd_addr_q.size(), 32'd8);
    check_eq("t2_rd_first", qget(rd_addr_q, 0), 32'h2000);
    check_eq("t2_rd_last", qget(rd_addr_q, 7), 32'h201C);
    access(0, 1'b0, 32'h0808, 32'h0, 4'hf, rd, st);
    check_eq("t2_other_line", rd, 32'h6932_5678);

    // 3: read 8 again -> writeback of 0x2000 line, refill from 0x0
    clear_logs();
    access(0, 1'b0, 32'h8, 32'h0, 4'hf, rd, st);
    check_eq("t3_rdata", rd, 32'h1234_5678);
    check_eq("t3_wr_cnt", wr_addr_q.size(), 32'd8);
    check_eq("t3_wr_first", qget(wr_addr_q, 0), 32'h2000);
    check_eq("t3_wr_word2", qget(wr_data_q, 2), 32'h5858_5678);
    check_eq("t3_wr_word0", qget(wr_data_q, 0), 32'hC0DE_2000);
    check_eq("t3_rd_first", qget(rd_addr_q, 0), 32'h0);
    check_eq("t3_rd_last", qget(rd_addr_q, 7), 32'h1C);

    // 4: partial byte-enable merge, and byteEnable=0 still dirties
    access(0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0011, rd, st);
    access(0, 1'b0, 32'h8, 32'h0, 4'hf, rd, st);
    check_eq("t4_merge", rd, 32'h1234_CCDD);
    access(0, 1'b0, 32'h40, 32'h0, 4'hf, rd, st);
    check_eq("t4_clean_fill", rd, 32'hC0DE_0040);
    access(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, rd, st);
    access(0, 1'b0, 32'h40, 32'h0, 4'hf, rd, st);
    check_eq("t4_be0_nochange", rd, 32'hC0DE_0040);
    clear_logs();
    access(0, 1'b0, 32'h2040, 32'h0, 4'hf, rd, st);
    check_eq("t4_evict_rdata", rd, 32'hC0DE_2040);
    check_eq("t4_be0_dirty_wb", wr_addr_q.size(), 32'd8);
    check_eq("t4_wb_addr", qget(wr_addr_q, 0), 32'h40);

    // 5: simultaneous hits on s0 and s1 -> s0 first, s1 next cycle
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hf);
    drive(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hf);
    #1;
    check_eq("t5_s0_wait", s0_waitRequest, 32'd0);
    check_eq("t5_s1_wait", s1_waitRequest, 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("t5_s0_rdv", s0_readDataValid, 32'd1);
    check_eq("t5_s0_rdata", s0_readData, 32'h1234_CCDD);
    #1;
    check_eq("t5_s1_wait2", s1_waitRequest, 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("t5_s1_rdv", s1_readDataValid, 32'd1);
    check_eq("t5_s1_rdata", s1_readData, 32'hC0DE_000C);
    check_eq("t5_s0_rdv_drop", s0_readDataValid, 32'd0);

    // 6: reset in the middle of a refill
    @(negedge clk);
    b0 = beats_seen;
    drive(0, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hf);
    n = 0;
    while ((beats_seen - b0) < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_fill_started", {31'b0, (beats_seen - b0) >= 3}, 32'd1);
    rest = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("t6_m0_read_drop", m0_read, 32'd0);
    check_eq("t6_rst_wait", s0_waitRequest, 32'd1);
    repeat (3) @(negedge clk);
    rest = 1'b0;
    clear_logs();
    access(0, 1'b0, 32'h4000, 32'h0, 4'hf, rd, st);
    check_eq("t6_rdata", rd, 32'hC0DE_4000);
    check_eq("t6_rd_cnt", rd_addr_q.size(), 32'd8);
    check_eq("t6_rd_first", qget(rd_addr_q, 0), 32'h4000);
    check_eq("t6_rd_last", qget(rd_addr_q, 7), 32'h401C);
    check_eq("t6_wr_cnt", wr_addr_q.size(), 32'd0);

    // Protocol invariants over the whole run
    check_eq("m0_rd_wr_overlap", both_cnt, 32'd0);
    check_eq("m0_cmd_fields", proto_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
